univ_shift_reg: RTL and testbench

Parametrised universal shift register: DEPTH stages, each WIDTH bits wide, with hold, shift-up, shift-down and parallel-load modes. It also has a synchronous clear and a saturating fill counter that reports how many lanes hold valid shifted or loaded data. It replaces the fixed 1-bit serial-in/serial-out register in the serialisation paths and serves both serial-to-parallel and parallel-to-serial conversion.

---
 rtl/usr_pkg.sv | 13 +
 rtl/usr_stage.sv | 40 ++++
 rtl/univ_shift_reg.sv | 112 +++++++++++
 tb/tb_univ_shift_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: mode encodings.
package usr_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'b00,
      SHIFT_UP = 2'b01,
      SHIFT_DN = 2'b10,
      LOAD     = 2'b11
   } usr_mode_e;

   localparam int USR_MODE_W = 2;

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit lane of the universal shift register.
// The next value is picked from hold, lower neighbour (shift up),
// upper neighbour (shift down) or the parallel-load slice.
module usr_stage
   import usr_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  usr_mode_e        sel,
   input  logic [WIDTH-1:0] up_in,
   input  logic [WIDTH-1:0] dn_in,
   input  logic [WIDTH-1:0] ld_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] nxt;

   // Next-value mux selected by the shift mode.
   always_comb begin
      nxt = q;
      unique case (sel)
         HOLD:     nxt = q;
         SHIFT_UP: nxt = up_in;
         SHIFT_DN: nxt = dn_in;
         LOAD:     nxt = ld_in;
         default:  nxt = q;
      endcase
   end

   // Lane register: async reset, then synchronous clear, then mux value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      q <= '0;
      else if (clr) q <= '0;
      else          q <= nxt;
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH lanes of WIDTH bits with hold,
// shift-up, shift-down and parallel load, plus a saturating count of
// lanes holding valid data.
// Optional feature macro: USR_ROTATE_EN adds the rot input, turning a
// shift into a circular rotate that ignores d and leaves cnt alone.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic [1:0]                 mode,
   input  logic [WIDTH-1:0]           d,
   input  logic [DEPTH*WIDTH-1:0]     pd,
   output logic [WIDTH-1:0]           q_up,
   output logic [WIDTH-1:0]           q_dn,
   output logic [DEPTH*WIDTH-1:0]     pq,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       full
`ifdef USR_ROTATE_EN
   ,
   input  logic                       rot
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   usr_mode_e        mode_e;
   logic             rotating;
   logic [WIDTH-1:0] up_end;
   logic [WIDTH-1:0] dn_end;
   logic [WIDTH-1:0] stg    [DEPTH];
   logic [WIDTH-1:0] up_src [DEPTH];
   logic [WIDTH-1:0] dn_src [DEPTH];
   logic [CW-1:0]    cnt_nxt;

   assign mode_e = usr_mode_e'(mode);

`ifdef USR_ROTATE_EN
   assign rotating = rot;
`else
   assign rotating = 1'b0;
`endif

   // End lanes take the serial input, or the opposite end when rotating.
   assign up_end = rotating ? stg[DEPTH-1] : d;
   assign dn_end = rotating ? stg[0]       : d;

   for (genvar i = 0; i < DEPTH; i++) begin : g_lane
      if (i == 0) begin : g_lo
         assign up_src[i] = up_end;
      end else begin : g_lo
         assign up_src[i] = stg[i-1];
      end

      if (i == DEPTH-1) begin : g_hi
         assign dn_src[i] = dn_end;
      end else begin : g_hi
         assign dn_src[i] = stg[i+1];
      end

      usr_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr),
         .sel   (mode_e),
         .up_in (up_src[i]),
         .dn_in (dn_src[i]),
         .ld_in (pd[i*WIDTH +: WIDTH]),
         .q     (stg[i])
      );

      assign pq[i*WIDTH +: WIDTH] = stg[i];
   end

   assign q_up = stg[DEPTH-1];
   assign q_dn = stg[0];

   // Next fill count: saturates at DEPTH, untouched by rotates.
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else begin
         unique case (mode_e)
            LOAD: cnt_nxt = CNT_MAX;
            SHIFT_UP, SHIFT_DN: begin
               if (!rotating && (cnt != CNT_MAX)) cnt_nxt = cnt + CW'(1);
            end
            default: cnt_nxt = cnt;
         endcase
      end
   end

   // Count and full flag registered together so full tracks cnt exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         full <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         full <= (cnt_nxt == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg, WIDTH=1, DEPTH=4.
// Optional macro USR_ROTATE_EN enables the rotate scenarios.
module tb_univ_shift_reg;

   localparam int WIDTH = 1;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [1:0] mode;
   logic       d;
   logic [3:0] pd;
   logic       q_up;
   logic       q_dn;
   logic [3:0] pq;
   logic [2:0] cnt;
   logic       full;
   logic       rot;

   typedef struct {
      logic [3:0] pq;
      logic [2:0] cnt;
      logic       full;
   } exp_t;

   exp_t       sb_q [$];
   logic [3:0] m_pq;
   int         m_cnt;
   int         n_checks;
   int         n_errors;

   univ_shift_reg #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .mode (mode),
      .d    (d),
      .pd   (pd),
      .q_up (q_up),
      .q_dn (q_dn),
      .pq   (pq),
      .cnt  (cnt),
      .full (full)
`ifdef USR_ROTATE_EN
      ,
      .rot  (rot)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, push the model's prediction, then
   // compare the DUT against the popped prediction after the edge.
   task automatic step(input logic c, input logic [1:0] m, input logic din,
                       input logic [3:0] p, input logic r);
      exp_t e;
      logic rr;
      @(negedge clk);
      clr  = c;
      mode = m;
      d    = din;
      pd   = p;
      rot  = r;
`ifdef USR_ROTATE_EN
      rr = r;
`else
      rr = 1'b0;
`endif
      if (c) begin
         m_pq  = 4'b0000;
         m_cnt = 0;
      end else begin
         case (m)
            2'b01: begin
               m_pq = rr ? {m_pq[2:0], m_pq[3]} : {m_pq[2:0], din};
               if (!rr && m_cnt < DEPTH) m_cnt++;
            end
            2'b10: begin
               m_pq = rr ? {m_pq[0], m_pq[3:1]} : {din, m_pq[3:1]};
               if (!rr && m_cnt < DEPTH) m_cnt++;
            end
            2'b11: begin
               m_pq  = p;
               m_cnt = DEPTH;
            end
            default: ;
         endcase
      end
      e.pq   = m_pq;
      e.cnt  = 3'(m_cnt);
      e.full = (m_cnt == DEPTH);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("pq",   32'(pq),   32'(e.pq));
         check("cnt",  32'(cnt),  32'(e.cnt));
         check("full", 32'(full), 32'(e.full));
         check("q_up", 32'(q_up), 32'(e.pq[3]));
         check("q_dn", 32'(q_dn), 32'(e.pq[0]));
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_pq     = 4'b0000;
      m_cnt    = 0;
      rot      = 1'b0;

      // Reset with random stimulus on the inputs.
      rst  = 1'b1;
      clr  = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      d    = 1'($urandom_range(0, 1));
      pd   = 4'($urandom_range(0, 15));
      repeat (2) @(posedge clk);
      #1;
      check("rst_pq",   32'(pq),   32'h0);
      check("rst_cnt",  32'(cnt),  32'h0);
      check("rst_full", 32'(full), 32'h0);
      @(negedge clk);
      rst  = 1'b0;
      clr  = 1'b0;
      mode = 2'b00;
      step(1'b0, 2'b00, 1'b1, 4'hF, 1'b0);
      check("post_rst_pq", 32'(pq), 32'h0);

      // Four shift-ups then a saturating fifth.
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b0, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      check("up_pq",   32'(pq),   32'hB);
      check("up_q_up", 32'(q_up), 32'h1);
      check("up_cnt",  32'(cnt),  32'd4);
      check("up_full", 32'(full), 32'h1);
      step(1'b0, 2'b01, 1'b0, 4'h0, 1'b0);
      check("sat_cnt", 32'(cnt), 32'd4);

      // Load then shift down.
      step(1'b0, 2'b11, 1'b0, 4'h8, 1'b0);
      check("ld_cnt", 32'(cnt), 32'd4);
      step(1'b0, 2'b10, 1'b0, 4'h0, 1'b0);
      check("dn1_pq",   32'(pq),   32'h4);
      check("dn1_q_dn", 32'(q_dn), 32'h0);
      step(1'b0, 2'b10, 1'b1, 4'h0, 1'b0);
      check("dn2_pq", 32'(pq), 32'hA);

      // Clear beats load, then hold.
      step(1'b1, 2'b11, 1'b0, 4'hF, 1'b0);
      check("clr_pq",   32'(pq),   32'h0);
      check("clr_cnt",  32'(cnt),  32'd0);
      check("clr_full", 32'(full), 32'h0);
      repeat (3) step(1'b0, 2'b00, 1'b1, 4'hF, 1'b0);
      check("hold_pq", 32'(pq), 32'h0);

      // Async reset between edges after two shifts.
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      mode = 2'b00;
      #1 rst = 1'b1;
      #1;
      check("arst_pq",   32'(pq),   32'h0);
      check("arst_cnt",  32'(cnt),  32'd0);
      check("arst_full", 32'(full), 32'h0);
      rst   = 1'b0;
      m_pq  = 4'b0000;
      m_cnt = 0;
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      check("arst_up_pq",  32'(pq),  32'h1);
      check("arst_up_cnt", 32'(cnt), 32'd1);

`ifdef USR_ROTATE_EN
      // Rotates wrap end lanes and leave the count alone.
      step(1'b0, 2'b11, 1'b0, 4'h9, 1'b0);
      step(1'b0, 2'b01, 1'b0, 4'h0, 1'b1);
      check("rot_up_pq",  32'(pq),  32'h3);
      check("rot_up_cnt", 32'(cnt), 32'd4);
      step(1'b0, 2'b10, 1'b0, 4'h0, 1'b1);
      check("rot_dn_pq", 32'(pq), 32'h9);
      step(1'b1, 2'b00, 1'b0, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b1, 4'h0, 1'b0);
      step(1'b0, 2'b01, 1'b0, 4'h0, 1'b1);
      check("rot_part_pq",  32'(pq),  32'h2);
      check("rot_part_cnt", 32'(cnt), 32'd1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
